// File: rtl/ps2_key_decoder_if.sv
// Byte-stream input and key-event FIFO output bundle of the PS/2 key decoder.
// master = byte source / event consumer, slave = the decoder itself.
interface ps2_key_decoder_if #(
    parameter int FIFO_DEPTH = 8
) ();
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]    byte_in;
    logic          byte_valid;
    logic          pop;
    logic          clear_overflow;
    logic [7:0]    event_ascii;
    logic [7:0]    event_code;
    logic          event_release;
    logic          event_extended;
    logic          fifo_empty;
    logic          fifo_full;
    logic [CW-1:0] fifo_count;
    logic          overflow;
    logic [7:0]    last_data_received;

    modport master (
        output byte_in, byte_valid, pop, clear_overflow,
        input  event_ascii, event_code, event_release, event_extended,
               fifo_empty, fifo_full, fifo_count, overflow, last_data_received
    );

    modport slave (
        input  byte_in, byte_valid, pop, clear_overflow,
        output event_ascii, event_code, event_release, event_extended,
               fifo_empty, fifo_full, fifo_count, overflow, last_data_received
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 key decoder: E0/F0 prefix tracking, scancode->ASCII translation,
// show-ahead event FIFO with sticky overflow, and a last-pressed ASCII register.
module ps2_key_decoder #(
    parameter int FIFO_DEPTH     = 8,
    parameter bit REPORT_RELEASE = 1'b0
) (
    input  logic             inclock,
    input  logic             resetn,
    ps2_key_decoder_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

    typedef struct packed {
        logic [7:0] ascii;
        logic [7:0] code;
        logic       rel;
        logic       ext;
    } entry_t;

    function automatic logic [7:0] to_ascii(input logic [7:0] sc);
        case (sc)
            8'h1C: return 8'h41;  8'h32: return 8'h42;  8'h21: return 8'h43;
            8'h23: return 8'h44;  8'h24: return 8'h45;  8'h2B: return 8'h46;
            8'h34: return 8'h47;  8'h33: return 8'h48;  8'h43: return 8'h49;
            8'h3B: return 8'h4A;  8'h42: return 8'h4B;  8'h4B: return 8'h4C;
            8'h3A: return 8'h4D;  8'h31: return 8'h4E;  8'h44: return 8'h4F;
            8'h4D: return 8'h50;  8'h15: return 8'h51;  8'h2D: return 8'h52;
            8'h1B: return 8'h53;  8'h2C: return 8'h54;  8'h3C: return 8'h55;
            8'h2A: return 8'h56;  8'h1D: return 8'h57;  8'h22: return 8'h58;
            8'h35: return 8'h59;  8'h1A: return 8'h5A;
            8'h45: return 8'h30;  8'h16: return 8'h31;  8'h1E: return 8'h32;
            8'h26: return 8'h33;  8'h25: return 8'h34;  8'h2E: return 8'h35;
            8'h36: return 8'h36;  8'h3D: return 8'h37;  8'h3E: return 8'h38;
            8'h46: return 8'h39;
            8'h29: return 8'h20;  8'h5A: return 8'h0D;  8'h66: return 8'h08;
            default: return 8'h00;
        endcase
    endfunction

    state_t        state_q, state_d;
    entry_t        mem_q [FIFO_DEPTH];
    entry_t        mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d, empty_q, empty_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    last_q, last_d;

    logic   evt, evt_rel, evt_ext, push, do_pop, accept, drop;
    entry_t new_entry, head;

    always_comb begin
        state_d   = state_q;
        evt       = 1'b0;
        evt_rel   = (state_q == S_BRK) || (state_q == S_EXT_BRK);
        evt_ext   = (state_q == S_EXT) || (state_q == S_EXT_BRK);
        if (bus.byte_valid) begin
            if (bus.byte_in inside {8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFE, 8'hFF})
                state_d = S_IDLE;
            else if (bus.byte_in == 8'hE0)
                state_d = evt_rel ? S_EXT_BRK : S_EXT;
            else if (bus.byte_in == 8'hF0)
                state_d = evt_ext ? S_EXT_BRK : S_BRK;
            else begin
                evt     = 1'b1;
                state_d = S_IDLE;
            end
        end

        new_entry.ascii = evt_ext ? 8'h00 : to_ascii(bus.byte_in);
        new_entry.code  = bus.byte_in;
        new_entry.rel   = evt_rel;
        new_entry.ext   = evt_ext;

        // A pop frees a slot in the same cycle, so a full FIFO can still accept
        push   = evt && (!evt_rel || REPORT_RELEASE);
        do_pop = bus.pop && !empty_q;
        accept = push && (!full_q || do_pop);
        drop   = push && full_q && !do_pop;

        mem_d = mem_q;
        if (accept)
            mem_d[wr_ptr_q] = new_entry;
        wr_ptr_d = accept ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(accept) - CW'(do_pop);
        full_d   = (count_d == CW'(FIFO_DEPTH));
        empty_d  = (count_d == '0);

        overflow_d = drop ? 1'b1 : (bus.clear_overflow ? 1'b0 : overflow_q);

        last_d = last_q;
        if (evt && !evt_rel && new_entry.ascii != 8'h00)
            last_d = new_entry.ascii;

        head = empty_q ? '0 : mem_q[rd_ptr_q];
    end

    always_ff @(posedge inclock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            last_q     <= 8'h00;
        end else begin
            state_q    <= state_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
            last_q     <= last_d;
        end
    end

    assign bus.event_ascii        = head.ascii;
    assign bus.event_code         = head.code;
    assign bus.event_release      = head.rel;
    assign bus.event_extended     = head.ext;
    assign bus.fifo_empty         = empty_q;
    assign bus.fifo_full          = full_q;
    assign bus.fifo_count         = count_q;
    assign bus.overflow           = overflow_q;
    assign bus.last_data_received = last_q;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: one instance dropping releases, one reporting them,
// both fed the same byte stream.
module tb_ps2_key_decoder;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ps2_key_decoder_if #(.FIFO_DEPTH(8)) if0 ();
    ps2_key_decoder_if #(.FIFO_DEPTH(8)) if1 ();

    ps2_key_decoder #(.FIFO_DEPTH(8), .REPORT_RELEASE(1'b0)) dut0 (
        .inclock(clk), .resetn(rst_n), .bus(if0.slave));
    ps2_key_decoder #(.FIFO_DEPTH(8), .REPORT_RELEASE(1'b1)) dut1 (
        .inclock(clk), .resetn(rst_n), .bus(if1.slave));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [23:0] bytes;
        int          n;
        bit          push0;
        bit          push1;
        logic [7:0]  ascii;
        logic [7:0]  code;
        bit          rel;
        bit          ext;
        logic [7:0]  last;
    } vec_t;

    vec_t vecs [15];

    localparam logic [7:0] FILL_SC [9] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24,
                                           8'h2B, 8'h34, 8'h33, 8'h43};
    localparam logic [7:0] DRAIN_A [8] = '{8'h43, 8'h44, 8'h45, 8'h46, 8'h47,
                                           8'h48, 8'h4C, 8'h4F};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic [7:0] b, input logic v, input logic p, input logic c);
        @(negedge clk);
        if0.byte_in = b; if0.byte_valid = v; if0.pop = p; if0.clear_overflow = c;
        if1.byte_in = b; if1.byte_valid = v; if1.pop = p; if1.clear_overflow = c;
    endtask

    task automatic idle();
        step(8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{24'h230000, 1, 1, 1, 8'h44, 8'h23, 0, 0, 8'h44};
        vecs[1]  = '{24'hF02300, 2, 0, 1, 8'h44, 8'h23, 1, 0, 8'h44};
        vecs[2]  = '{24'hE0F075, 3, 0, 1, 8'h00, 8'h75, 1, 1, 8'h44};
        vecs[3]  = '{24'hAA4200, 2, 1, 1, 8'h4B, 8'h42, 0, 0, 8'h4B};
        vecs[4]  = '{24'hE01C00, 2, 1, 1, 8'h00, 8'h1C, 0, 1, 8'h4B};
        vecs[5]  = '{24'h290000, 1, 1, 1, 8'h20, 8'h29, 0, 0, 8'h20};
        vecs[6]  = '{24'h5A0000, 1, 1, 1, 8'h0D, 8'h5A, 0, 0, 8'h0D};
        vecs[7]  = '{24'h660000, 1, 1, 1, 8'h08, 8'h66, 0, 0, 8'h08};
        vecs[8]  = '{24'h450000, 1, 1, 1, 8'h30, 8'h45, 0, 0, 8'h30};
        vecs[9]  = '{24'h460000, 1, 1, 1, 8'h39, 8'h46, 0, 0, 8'h39};
        vecs[10] = '{24'hE0E05A, 3, 1, 1, 8'h00, 8'h5A, 0, 1, 8'h39};
        vecs[11] = '{24'hF0E06B, 3, 0, 1, 8'h00, 8'h6B, 1, 1, 8'h39};
        vecs[12] = '{24'hF0F01A, 3, 0, 1, 8'h5A, 8'h1A, 1, 0, 8'h39};
        vecs[13] = '{24'h760000, 1, 1, 1, 8'h00, 8'h76, 0, 0, 8'h39};
        vecs[14] = '{24'hE0FA4D, 3, 1, 1, 8'h50, 8'h4D, 0, 0, 8'h50};

        if0.byte_in = '0; if0.byte_valid = 0; if0.pop = 0; if0.clear_overflow = 0;
        if1.byte_in = '0; if1.byte_valid = 0; if1.pop = 0; if1.clear_overflow = 0;

        #7;
        chk("rst_empty",    if1.fifo_empty, 1);
        chk("rst_full",     if1.fifo_full, 0);
        chk("rst_count",    if1.fifo_count, 0);
        chk("rst_overflow", if1.overflow, 0);
        chk("rst_last",     if1.last_data_received, 0);
        chk("rst_head",     {if1.event_ascii, if1.event_code, if1.event_release, if1.event_extended}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            for (int j = 0; j < vecs[i].n; j++)
                step(vecs[i].bytes[23-8*j -: 8], 1'b1, 1'b0, 1'b0);
            idle();
            chk($sformatf("v%0d_empty1", i), if1.fifo_empty, !vecs[i].push1);
            chk($sformatf("v%0d_empty0", i), if0.fifo_empty, !vecs[i].push0);
            if (vecs[i].push1) begin
                chk($sformatf("v%0d_ascii", i), if1.event_ascii, vecs[i].ascii);
                chk($sformatf("v%0d_code", i),  if1.event_code, vecs[i].code);
                chk($sformatf("v%0d_rel", i),   if1.event_release, vecs[i].rel);
                chk($sformatf("v%0d_ext", i),   if1.event_extended, vecs[i].ext);
                chk($sformatf("v%0d_count", i), if1.fifo_count, 1);
            end
            if (vecs[i].push0)
                chk($sformatf("v%0d_code0", i), if0.event_code, vecs[i].code);
            else
                chk($sformatf("v%0d_head0_zero", i), {if0.event_ascii, if0.event_code}, 0);
            chk($sformatf("v%0d_last1", i), if1.last_data_received, vecs[i].last);
            chk($sformatf("v%0d_last0", i), if0.last_data_received, vecs[i].last);
            step(8'h00, 1'b0, 1'b1, 1'b0);
            idle();
            chk($sformatf("v%0d_popped1", i), if1.fifo_empty, 1);
            chk($sformatf("v%0d_popped0", i), if0.fifo_empty, 1);
        end

        // Fill past capacity: ninth press is dropped but still updates last
        for (int k = 0; k < 9; k++)
            step(FILL_SC[k], 1'b1, 1'b0, 1'b0);
        idle();
        chk("fill_count", if1.fifo_count, 8);
        chk("fill_full",  if1.fifo_full, 1);
        chk("fill_ovf",   if1.overflow, 1);
        chk("fill_ovf0",  if0.overflow, 1);
        chk("fill_head",  if1.event_ascii, 8'h41);
        chk("fill_last",  if1.last_data_received, 8'h49);

        step(8'h4B, 1'b1, 1'b1, 1'b0);
        idle();
        chk("pp1_count", if1.fifo_count, 8);
        chk("pp1_full",  if1.fifo_full, 1);
        chk("pp1_ovf",   if1.overflow, 1);
        chk("pp1_head",  if1.event_ascii, 8'h42);
        chk("pp1_last",  if1.last_data_received, 8'h4C);

        step(8'h00, 1'b0, 1'b0, 1'b1);
        idle();
        chk("clr_ovf", if1.overflow, 0);

        step(8'h44, 1'b1, 1'b1, 1'b0);
        idle();
        chk("pp2_count", if1.fifo_count, 8);
        chk("pp2_ovf",   if1.overflow, 0);
        chk("pp2_head",  if1.event_ascii, 8'h43);

        for (int k = 0; k < 8; k++) begin
            chk($sformatf("drain%0d_head", k), if1.event_ascii, DRAIN_A[k]);
            chk($sformatf("drain%0d_count", k), if1.fifo_count, 8 - k);
            step(8'h00, 1'b0, 1'b1, 1'b0);
            idle();
        end
        chk("drain_empty", if1.fifo_empty, 1);
        chk("drain_full",  if1.fifo_full, 0);
        chk("drain_count", if1.fifo_count, 0);
        step(8'h00, 1'b0, 1'b1, 1'b0);
        idle();
        chk("xpop_count", if1.fifo_count, 0);
        chk("xpop_empty", if1.fifo_empty, 1);

        // Asynchronous reset right after a break prefix
        step(8'h1C, 1'b1, 1'b0, 1'b0);
        step(8'hF0, 1'b1, 1'b0, 1'b0);
        idle();
        chk("prerst_count", if1.fifo_count, 1);
        chk("prerst_last",  if1.last_data_received, 8'h41);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_empty", if1.fifo_empty, 1);
        chk("arst_count", if1.fifo_count, 0);
        chk("arst_head",  if1.event_ascii, 0);
        chk("arst_last",  if1.last_data_received, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(8'h35, 1'b1, 1'b0, 1'b0);
        idle();
        chk("post_ascii",  if1.event_ascii, 8'h59);
        chk("post_rel",    if1.event_release, 0);
        chk("post_last",   if1.last_data_received, 8'h59);
        chk("post_empty0", if0.fifo_empty, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
